// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control unit: FETCH/DECODE/execute FSM with a
// memory-wait watchdog that aborts stalled accesses back to FETCH.
module multicycle_control #(
    parameter int unsigned STALL_LIMIT = 15
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [5:0]  OPCODES,
    input  logic [5:0]  Funct,
    input  logic        MEM_READY,
    output logic [11:0] CTRLFLAGS,
    output logic [1:0]  PCSrc,
    output logic [4:0]  ALUSelect,
    output logic        INSTR_DONE,
    output logic        ILLEGAL,
    output logic        MEM_TIMEOUT
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXEC, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [4:0] ALU_AND = 5'b00000;
    localparam logic [4:0] ALU_OR  = 5'b00001;
    localparam logic [4:0] ALU_ADD = 5'b00010;
    localparam logic [4:0] ALU_SUB = 5'b00110;
    localparam logic [4:0] ALU_SLT = 5'b00111;
    localparam logic [4:0] ALU_BAD = 5'b11111;

    localparam logic [7:0] LIMIT_M1 = 8'(STALL_LIMIT - 1);

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [5:0]  opcode_q, opcode_d;
    logic [5:0]  funct_q, funct_d;
    logic        illegal_q, illegal_d;
    logic        timeout_q, timeout_d;

    logic        pc_write, branch, iord, mem_read, mem_write, ir_write;
    logic        reg_dst, memto_reg, reg_write, alu_src_a;
    logic [1:0]  alu_src_b;
    logic        wait_state, stall_abort;

    assign wait_state  = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                         (state_q == S_MEMWR);
    assign stall_abort = wait_state && !MEM_READY && (wait_cnt_q == LIMIT_M1);

    assign CTRLFLAGS   = {pc_write, branch, iord, mem_read, mem_write, ir_write,
                          reg_dst, memto_reg, reg_write, alu_src_a, alu_src_b};
    assign ILLEGAL     = illegal_q;
    assign MEM_TIMEOUT = timeout_q;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        opcode_d   = opcode_q;
        funct_d    = funct_q;
        illegal_d  = 1'b0;
        timeout_d  = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        memto_reg  = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        PCSrc      = 2'b00;
        ALUSelect  = ALU_ADD;
        INSTR_DONE = 1'b0;

        // Handshake strobes (IRWrite/PCWrite in FETCH, done in MEMWR) are
        // qualified by MEM_READY in the completing cycle; all else is state-only.
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (MEM_READY) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                opcode_d  = OPCODES;
                funct_d   = Funct;
                case (OPCODES)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode_q == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                if (MEM_READY) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                memto_reg  = 1'b1;
                reg_write  = 1'b1;
                INSTR_DONE = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = !stall_abort;
                if (MEM_READY) begin
                    INSTR_DONE = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                state_d   = S_ALUWB;
                case (funct_q)
                    6'b100000: ALUSelect = ALU_ADD;
                    6'b100010: ALUSelect = ALU_SUB;
                    6'b100100: ALUSelect = ALU_AND;
                    6'b100101: ALUSelect = ALU_OR;
                    6'b101010: ALUSelect = ALU_SLT;
                    default: begin
                        ALUSelect = ALU_BAD;
                        illegal_d = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_ALUWB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                INSTR_DONE = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                ALUSelect  = ALU_SUB;
                branch     = 1'b1;
                PCSrc      = 2'b01;
                INSTR_DONE = 1'b1;
                state_d    = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write  = 1'b1;
                INSTR_DONE = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                PCSrc      = 2'b10;
                pc_write   = 1'b1;
                INSTR_DONE = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Counter only runs while a wait state is stalled; leaving or entering
        // any state otherwise leaves it cleared.
        if (wait_state && !MEM_READY) begin
            if (stall_abort) begin
                state_d   = S_FETCH;
                timeout_d = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
            opcode_q   <= '0;
            funct_q    <= '0;
            illegal_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            opcode_q   <= opcode_d;
            funct_q    <= funct_d;
            illegal_q  <= illegal_d;
            timeout_q  <= timeout_d;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control (default and STALL_LIMIT=4).
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  opcodes = '0;
    logic [5:0]  funct = '0;
    logic        mem_ready = 1'b0;
    logic        mem_ready4 = 1'b0;

    logic [11:0] flags, flags4;
    logic [1:0]  pcsrc, pcsrc4;
    logic [4:0]  alu, alu4;
    logic        done, done4, ill, ill4, mt, mt4;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    multicycle_control dut (
        .CLK(clk), .RST(rst), .OPCODES(opcodes), .Funct(funct),
        .MEM_READY(mem_ready), .CTRLFLAGS(flags), .PCSrc(pcsrc),
        .ALUSelect(alu), .INSTR_DONE(done), .ILLEGAL(ill), .MEM_TIMEOUT(mt)
    );

    multicycle_control #(.STALL_LIMIT(4)) dut4 (
        .CLK(clk), .RST(rst), .OPCODES(opcodes), .Funct(funct),
        .MEM_READY(mem_ready4), .CTRLFLAGS(flags4), .PCSrc(pcsrc4),
        .ALUSelect(alu4), .INSTR_DONE(done4), .ILLEGAL(ill4), .MEM_TIMEOUT(mt4)
    );

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b0;
        mem_ready4 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (flags !== 12'h101) begin n_bad++; $display("FAIL reset_flags got %h want %h", flags, 12'h101); end
        n_cmp++; if (alu !== 5'b00010) begin n_bad++; $display("FAIL reset_alu got %b want %b", alu, 5'b00010); end
        n_cmp++; if ({pcsrc, done, ill, mt} !== 5'b0) begin n_bad++; $display("FAIL reset_pulses got %b want %b", {pcsrc, done, ill, mt}, 5'b0); end
        // Illegal opcode pulse must be killed asynchronously by reset.
        do_reset();
        opcodes = 6'b111111; mem_ready = 1'b1;
        @(negedge clk); mem_ready = 1'b0;
        @(negedge clk); #1;
        n_cmp++; if (ill !== 1'b1) begin n_bad++; $display("FAIL reset_ill_pre got %b want 1", ill); end
        #1 rst = 1'b1; #1;
        n_cmp++; if ({ill, done, flags} !== {2'b00, 12'h101}) begin n_bad++; $display("FAIL reset_async_ill got %h want %h", {ill, done, flags}, {2'b00, 12'h101}); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_lw();
        logic [11:0] ef [0:4] = '{12'h941, 12'h003, 12'h006, 12'h300, 12'h018};
        logic        ed [0:4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        opcodes = 6'b100011; funct = 6'b000000; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++; if (flags !== ef[i]) begin n_bad++; $display("FAIL lw_flags cyc%0d got %h want %h", i, flags, ef[i]); end
            n_cmp++; if (done !== ed[i]) begin n_bad++; $display("FAIL lw_done cyc%0d got %b want %b", i, done, ed[i]); end
            @(negedge clk);
        end
        #1;
        n_cmp++; if (flags !== 12'h941) begin n_bad++; $display("FAIL lw_refetch got %h want %h", flags, 12'h941); end
    endtask

    task automatic test_rtype();
        logic [11:0] ef [0:3] = '{12'h941, 12'h003, 12'h004, 12'h028};
        logic [4:0]  ea [0:3] = '{5'b00010, 5'b00010, 5'b00110, 5'b00010};
        logic        ed [0:3] = '{1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        opcodes = 6'b000000; funct = 6'b100010; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if (flags !== ef[i]) begin n_bad++; $display("FAIL rtype_flags cyc%0d got %h want %h", i, flags, ef[i]); end
            n_cmp++; if (alu !== ea[i]) begin n_bad++; $display("FAIL rtype_alu cyc%0d got %b want %b", i, alu, ea[i]); end
            n_cmp++; if (done !== ed[i]) begin n_bad++; $display("FAIL rtype_done cyc%0d got %b want %b", i, done, ed[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_sw_stall();
        logic        er [0:6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [11:0] ef [0:6] = '{12'h941, 12'h003, 12'h006, 12'h280, 12'h280, 12'h280, 12'h280};
        logic        ed [0:6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int unsigned pcw = 0;
        do_reset();
        opcodes = 6'b101011; funct = 6'b000000;
        for (int i = 0; i < 7; i++) begin
            mem_ready = er[i];
            #1;
            if (flags[11]) pcw++;
            n_cmp++; if (flags !== ef[i]) begin n_bad++; $display("FAIL sw_flags cyc%0d got %h want %h", i, flags, ef[i]); end
            n_cmp++; if (done !== ed[i]) begin n_bad++; $display("FAIL sw_done cyc%0d got %b want %b", i, done, ed[i]); end
            @(negedge clk);
        end
        mem_ready = 1'b0; #1;
        n_cmp++; if (flags !== 12'h101) begin n_bad++; $display("FAIL sw_refetch got %h want %h", flags, 12'h101); end
        n_cmp++; if (pcw !== 1) begin n_bad++; $display("FAIL sw_pcwrite_count got %0d want 1", pcw); end
    endtask

    task automatic test_illegal();
        logic [11:0] ef [0:3] = '{12'h941, 12'h003, 12'h101, 12'h101};
        logic        ei [0:3] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [11:0] gf [0:4] = '{12'h941, 12'h003, 12'h004, 12'h101, 12'h101};
        logic [4:0]  ga [0:4] = '{5'b00010, 5'b00010, 5'b11111, 5'b00010, 5'b00010};
        logic        gi [0:4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        opcodes = 6'b111111; funct = 6'b000000;
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 0);
            #1;
            n_cmp++; if (flags !== ef[i]) begin n_bad++; $display("FAIL illop_flags cyc%0d got %h want %h", i, flags, ef[i]); end
            n_cmp++; if (ill !== ei[i]) begin n_bad++; $display("FAIL illop_pulse cyc%0d got %b want %b", i, ill, ei[i]); end
            @(negedge clk);
        end
        do_reset();
        opcodes = 6'b000000; funct = 6'b000111;
        for (int i = 0; i < 5; i++) begin
            mem_ready = (i == 0);
            #1;
            n_cmp++; if (flags !== gf[i]) begin n_bad++; $display("FAIL illfn_flags cyc%0d got %h want %h", i, flags, gf[i]); end
            n_cmp++; if (alu !== ga[i]) begin n_bad++; $display("FAIL illfn_alu cyc%0d got %b want %b", i, alu, ga[i]); end
            n_cmp++; if (ill !== gi[i]) begin n_bad++; $display("FAIL illfn_pulse cyc%0d got %b want %b", i, ill, gi[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_branch_jump_addi();
        logic [5:0]  ops [0:2] = '{6'b000100, 6'b000010, 6'b001000};
        logic [11:0] lf  [0:2] = '{12'h404, 12'h800, 12'h006};
        logic [1:0]  lp  [0:2] = '{2'b01, 2'b10, 2'b00};
        logic [4:0]  la  [0:2] = '{5'b00110, 5'b00010, 5'b00010};
        logic        ld  [0:2] = '{1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 3; k++) begin
            do_reset();
            opcodes = ops[k]; mem_ready = 1'b1;
            @(negedge clk); mem_ready = 1'b0;
            @(negedge clk); #1;
            n_cmp++; if ({flags, pcsrc, alu, done} !== {lf[k], lp[k], la[k], ld[k]}) begin
                n_bad++; $display("FAIL exec_op%b got %h/%b/%b/%b want %h/%b/%b/%b", ops[k], flags, pcsrc, alu, done, lf[k], lp[k], la[k], ld[k]);
            end
        end
        @(negedge clk); #1;
        n_cmp++; if ({flags, done} !== {12'h008, 1'b1}) begin n_bad++; $display("FAIL addi_wb got %h/%b want %h/1", flags, done, 12'h008); end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if ({flags4, mt4, done4} !== {12'h101, 2'b00}) begin n_bad++; $display("FAIL to_wait cyc%0d got %h want %h", i, {flags4, mt4, done4}, {12'h101, 2'b00}); end
            n_cmp++; if (mt !== 1'b0) begin n_bad++; $display("FAIL to_default_early cyc%0d got %b want 0", i, mt); end
            @(negedge clk);
        end
        #1;
        n_cmp++; if ({flags4, mt4} !== {12'h101, 1'b1}) begin n_bad++; $display("FAIL to_pulse got %h want %h", {flags4, mt4}, {12'h101, 1'b1}); end
        @(negedge clk); #1;
        n_cmp++; if (mt4 !== 1'b0) begin n_bad++; $display("FAIL to_pulse_width got %b want 0", mt4); end
        mem_ready4 = 1'b1; #1;
        n_cmp++; if (flags4 !== 12'h941) begin n_bad++; $display("FAIL to_refetch got %h want %h", flags4, 12'h941); end
    endtask

    task automatic test_reset_memwr();
        do_reset();
        opcodes = 6'b101011; mem_ready = 1'b1;
        @(negedge clk); mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        n_cmp++; if (flags !== 12'h280) begin n_bad++; $display("FAIL rstwr_pre got %h want %h", flags, 12'h280); end
        #2 rst = 1'b1; #1;
        n_cmp++; if (flags !== 12'h101) begin n_bad++; $display("FAIL rstwr_async got %h want %h", flags, 12'h101); end
        @(negedge clk); rst = 1'b0; #1;
        n_cmp++; if (flags !== 12'h101) begin n_bad++; $display("FAIL rstwr_fetch got %h want %h", flags, 12'h101); end
        mem_ready = 1'b1;
        @(negedge clk); mem_ready = 1'b0; #1;
        n_cmp++; if (flags !== 12'h003) begin n_bad++; $display("FAIL rstwr_decode got %h want %h", flags, 12'h003); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype();
        test_sw_stall();
        test_illegal();
        test_branch_jump_addi();
        test_timeout();
        test_reset_memwr();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
